// File: rtl/add4_seq_pkg.sv
// Shared encodings for the nibble-serial adder controller.
// Encoding 2'd3 is unused and recovers to ST_IDLE.
package add4_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add4_seq_ctrl_add4.sv
// ADD_4: 4-bit carry-lookahead adder slice.
// Used as the single shared datapath of add4_seq_ctrl.
module ADD_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is flattened from cin, so no carry ripples between bits.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/add4_seq_ctrl.sv
// Area-minimal WIDTH-bit add/subtract: one nibble per cycle through a single ADD_4,
// least significant first, with valid/ready handshakes on both sides.
module add4_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);
  import add4_seq_pkg::*;

  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic [3:0]       nibA, nibB, nibS;
  logic             nibCout;

  always_comb begin
    nibA = '0;
    nibB = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (idx_q == IDXW'(k)) begin
        nibA = a_q[4*k +: 4];
        nibB = b_q[4*k +: 4];
      end
    end
  end

  ADD_4 u_add4 (
    .a    (nibA),
    .b    (nibB),
    .cin  (carry_q),
    .s    (nibS),
    .cout (nibCout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        // Subtract is a + ~b + 1; the +1 enters as the initial carry.
        if (in_valid) begin
          a_d     = in_a;
          b_d     = (in_op == OP_SUB) ? ~in_b : in_b;
          carry_d = in_op;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int k = 0; k < NSLICE; k++) begin
          if (idx_q == IDXW'(k)) begin
            res_d[4*k +: 4] = nibS;
          end
        end
        carry_d = nibCout;
        if (idx_q == IDXW'(NSLICE - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign out_res   = res_q;
  assign out_cout  = carry_q;
  // Overflow: operands agree in sign but the result does not.
  assign out_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_q[WIDTH-1] != a_q[WIDTH-1]);

endmodule

// File: tb/tb_add4_seq_ctrl.sv
// Self-checking bench for add4_seq_ctrl (WIDTH=16): directed corner cases plus
// random transactions, compared against an integer-arithmetic reference model.
module tb_add4_seq_ctrl;

  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic             out_cout;
  logic             out_ovf;
  logic             busy;

  int checkCount = 0;
  int errorCount = 0;

  add4_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic on the operands.
  task automatic computeExpected(input logic op, input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] res, output logic cout, output logic ovf);
    int u;
    int s;
    if (op) begin
      u    = int'(a) - int'(b);
      s    = int'($signed(a)) - int'($signed(b));
      cout = (a >= b);
    end else begin
      u    = int'(a) + int'(b);
      s    = int'($signed(a)) + int'($signed(b));
      cout = (u > 65535);
    end
    res = u[15:0];
    ovf = (s > 32767) || (s < -32768);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic scrambleInputs();
    in_a  = 16'($urandom);
    in_b  = 16'($urandom);
    in_op = 1'($urandom);
  endtask

  // One full transaction: offer operands, follow RUN, hold DONE, hand off.
  task automatic applyStimulus(input logic op, input logic [15:0] a, input logic [15:0] b,
                               input int holdCycles, input bit keepValid,
                               input bit expectNoWait, input string tag);
    logic [15:0] expRes;
    logic        expCout;
    logic        expOvf;
    int          waitCnt;
    int          latency;
    bit          runBad;
    computeExpected(op, a, b, expRes, expCout, expOvf);
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    out_ready = (holdCycles == 0);
    waitCnt   = 0;
    while (!in_ready && waitCnt < 50) begin
      stepCycle();
      waitCnt++;
    end
    checkOutput({tag, "_acceptReady"}, 32'(in_ready), 32'd1);
    if (expectNoWait) checkOutput({tag, "_b2bGap"}, 32'(waitCnt), 32'd0);
    stepCycle();
    if (!keepValid) in_valid = 1'b0;
    latency = 1;
    runBad  = 1'b0;
    while (!out_valid && latency < 50) begin
      if (in_ready || !busy) runBad = 1'b1;
      scrambleInputs();
      stepCycle();
      latency++;
    end
    checkOutput({tag, "_latency"}, 32'(latency), 32'(NSLICE + 1));
    checkOutput({tag, "_runHandshake"}, 32'(runBad), 32'd0);
    checkOutput({tag, "_res"}, 32'(out_res), 32'(expRes));
    checkOutput({tag, "_cout"}, 32'(out_cout), 32'(expCout));
    checkOutput({tag, "_ovf"}, 32'(out_ovf), 32'(expOvf));
    for (int h = 0; h < holdCycles; h++) begin
      scrambleInputs();
      stepCycle();
      checkOutput({tag, "_holdValid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_holdRes"}, {15'd0, out_cout, out_ovf, out_res},
                  {15'd0, expCout, expOvf, expRes});
      checkOutput({tag, "_holdBusyReady"}, {30'd0, busy, in_ready}, 32'b10);
    end
    out_ready = 1'b1;
    stepCycle();
    out_ready = 1'b0;
    checkOutput({tag, "_handoff"}, {29'd0, out_valid, in_ready, busy}, 32'b010);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rop;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    stepCycle();
    stepCycle();
    rst = 1'b0;
    checkOutput("reset", {26'd0, in_ready, out_valid, busy, out_cout, out_ovf, |out_res},
                32'b100000);

    $display("[TB] directed cases");
    applyStimulus(1'b0, 16'h1234, 16'h0FCD, 0, 1'b0, 1'b0, "add1234");
    applyStimulus(1'b0, 16'hFFFF, 16'h0001, 0, 1'b0, 1'b0, "addWrap");
    applyStimulus(1'b0, 16'h7FFF, 16'h0001, 0, 1'b0, 1'b0, "addOvf");
    applyStimulus(1'b1, 16'h0005, 16'h0007, 0, 1'b0, 1'b0, "subBorrow");
    applyStimulus(1'b1, 16'h8000, 16'h0001, 0, 1'b0, 1'b0, "subOvf");

    $display("[TB] backpressure");
    applyStimulus(1'b1, 16'hA5C3, 16'h3C5A, 3, 1'b1, 1'b0, "backpressure");
    in_valid = 1'b0;

    $display("[TB] reset in RUN");
    in_valid = 1'b1;
    in_op    = 1'b0;
    in_a     = 16'hFFFF;
    in_b     = 16'hFFFF;
    stepCycle();
    in_valid = 1'b0;
    stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("midReset", {26'd0, in_ready, out_valid, busy, out_cout, out_ovf, |out_res},
                32'b100000);
    for (int i = 0; i < 6; i++) begin
      stepCycle();
      checkOutput("midResetNoValid", 32'(out_valid), 32'd0);
    end
    applyStimulus(1'b0, 16'h0001, 16'h0001, 0, 1'b0, 1'b0, "afterReset");

    $display("[TB] back-to-back");
    applyStimulus(1'b0, 16'h4321, 16'h1111, 0, 1'b1, 1'b0, "b2bFirst");
    applyStimulus(1'b1, 16'h0100, 16'h0200, 0, 1'b0, 1'b1, "b2bSecond");

    $display("[TB] random transactions");
    for (int n = 0; n < 40; n++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rop = 1'($urandom);
      applyStimulus(rop, ra, rb, int'($urandom_range(0, 2)), 1'($urandom), 1'b0, "random");
    end
    in_valid = 1'b0;
    stepCycle();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
